// File: rtl/serial_feeder_pkg.sv
// Shared types and constants for the serial_feeder block.
// The state encoding is visible to the top and to any bench that needs it.
package serial_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Width of a down-counter that must represent 0..w inclusive.
  function automatic int bl_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_feeder_if.sv
// Word handshake plus serial output bundle between an upstream producer and serial_feeder.
// master = producer side, slave = serial_feeder side.
interface serial_feeder_if
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                          load;
  logic [WIDTH-1:0]              data;
  logic                          hold;
  logic                          ready;
  logic                          x;
  logic                          valid;
  logic                          done;
  logic [bl_width(WIDTH)-1:0]    bits_left;

  modport master (
    output load, data, hold,
    input  ready, x, valid, done, bits_left
  );

  modport slave (
    input  load, data, hold,
    output ready, x, valid, done, bits_left
  );

endinterface

// File: rtl/serial_feeder_piso_reg.sv
// Parallel-load shift register; serial_o always shows the bit that goes out next.
// Load wins over shift when both are asserted.
module piso_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             serial_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign serial_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_feeder.sv
// Parallel-in/serial-out front end driving the single-bit x input of the downstream controller.
// Two-state FSM with a bits_left counter; supports hold stalls and gapless back-to-back words.
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic          CLK,
  input  logic          RESET,
  serial_feeder_if.slave bus
);

  localparam int BLW = bl_width(WIDTH);

  state_e           state_q, state_d;
  logic [BLW-1:0]   bits_left_q, bits_left_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ready;
  logic             accept;
  logic             last_bit;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_serial;

  assign last_bit = (state_q == ST_SHIFT) && (bits_left_q == BLW'(1)) && !bus.hold;
  assign ready    = (state_q == ST_IDLE) || last_bit;
  assign accept   = bus.load && ready;

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    if (accept) begin
      // A load on the final bit chains the next word with no idle gap.
      state_d     = ST_SHIFT;
      bits_left_d = BLW'(WIDTH);
      valid_d     = 1'b1;
      done_d      = last_bit;
      sr_load     = 1'b1;
    end else if (state_q == ST_SHIFT && !bus.hold) begin
      if (bits_left_q == BLW'(1)) begin
        state_d     = ST_IDLE;
        bits_left_d = '0;
        valid_d     = 1'b0;
        done_d      = 1'b1;
      end else begin
        bits_left_d = bits_left_q - BLW'(1);
        sr_shift    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  piso_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk_i    (CLK),
    .srst_i   (RESET),
    .load_i   (sr_load),
    .shift_i  (sr_shift),
    .data_i   (bus.data),
    .serial_o (sr_serial)
  );

  assign bus.ready     = ready;
  assign bus.x         = valid_q ? sr_serial : IDLE_BIT;
  assign bus.valid     = valid_q;
  assign bus.done      = done_q;
  assign bus.bits_left = bits_left_q;

endmodule

// File: tb/tb_serial_feeder.sv
// Directed plus random stimulus for serial_feeder, checked each cycle against a bit-queue model.
module tb_serial_feeder;
  import serial_feeder_pkg::*;

  localparam int WIDTH     = 8;
  localparam bit MSB_FIRST = 1'b1;
  localparam bit IDLE_BIT  = 1'b0;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  // Model: the payload bits still to present, front = bit currently on x.
  bit   mq[$];
  bit   m_done = 1'b0;

  serial_feeder_if #(.WIDTH(WIDTH)) bus ();

  serial_feeder #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDLE_BIT  (IDLE_BIT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic l, input logic [WIDTH-1:0] d, input logic h);
    bit exp_ready;
    RESET    = r;
    bus.load = l;
    bus.data = d;
    bus.hold = h;
    #1;
    exp_ready = (mq.size() == 0) || (mq.size() == 1 && !h);
    check("ready", 32'(bus.ready), 32'(exp_ready));
    check("valid", 32'(bus.valid), 32'(mq.size() != 0));
    check("x", 32'(bus.x), 32'((mq.size() != 0) ? mq[0] : IDLE_BIT));
    check("done", 32'(bus.done), 32'(m_done));
    check("bits_left", 32'(bus.bits_left), 32'(mq.size()));
    $display("t=%0t rst=%0b load=%0b data=%02h hold=%0b | x=%0b valid=%0b done=%0b bits_left=%0d ready=%0b",
             $time, r, l, d, h, bus.x, bus.valid, bus.done, bus.bits_left, bus.ready);
    @(posedge CLK);
    if (r) begin
      mq.delete();
      m_done = 1'b0;
    end else if (l && exp_ready) begin
      m_done = (mq.size() == 1);
      mq.delete();
      for (int i = 0; i < WIDTH; i++) begin
        mq.push_back(MSB_FIRST ? d[WIDTH-1-i] : d[i]);
      end
    end else if (mq.size() != 0 && !h) begin
      void'(mq.pop_front());
      m_done = (mq.size() == 0);
    end else begin
      m_done = 1'b0;
    end
    @(negedge CLK);
  endtask

  initial begin
    RESET    = 1'b1;
    bus.load = 1'b0;
    bus.data = '0;
    bus.hold = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    // Reset values, hold in idle is harmless
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 1);

    // Plain word
    cycle(0, 1, 8'hA5, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 8'h00, 0);

    // Hold for 3 cycles while the 2nd bit is shown
    cycle(0, 1, 8'hA5, 0);
    cycle(0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 8'h00, 0);

    // Back-to-back words
    cycle(0, 1, 8'h0F, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 8'h00, 0);
    cycle(0, 1, 8'hF0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 8'h00, 0);

    // Load while busy is ignored
    cycle(0, 1, 8'h3C, 0);
    for (int i = 0; i < 10; i++) cycle(0, (i == 3), 8'hFF, 0);

    // Reset mid-word aborts it
    cycle(0, 1, 8'hC3, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 0);
    cycle(1, 1, 8'h55, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 8'h00, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) != 0),
            WIDTH'($urandom),
            ($urandom_range(0, 3) == 0));
    end
    cycle(0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
